serial_shift_tx: RTL
====================

# serial_shift_tx

Parallel-in, serial-out transmitter that accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock with framing strobes. It is the driving end of the single-bit serial path whose receive side is a chain of edge-triggered D flip-flops sampling `sout` on `clk`. It sits between a word-producing block and that flip-flop-based capture chain.

## Interface
- `WIDTH`, default 8: data word width; legal range WIDTH >= 2.
- `LSB_FIRST`, default 1: 1 = bit 0 transmitted first; 0 = bit WIDTH-1 first.
- `clk` input 1: single clock; all state updates on the rising edge.
- `clear` input 1: reset, synchronous and active-high.
- `load_valid` input 1: producer offers `load_data`.
- `load_ready` output 1: transmitter accepts a word this cycle.
- `load_data` input WIDTH: word to transmit; sampled only on acceptance.
- `sout` output 1: serial data bit.
- `sout_valid` output 1: `sout` carries a frame bit this cycle.
- `sout_first` output 1: first bit of a frame.
- `sout_last` output 1: final bit of a frame (data MSB/LSB, or parity bit when enabled).

## Operation
- Reset: while `clear`=1 at an edge → state IDLE, shift register 0, bit counter 0. All outputs 0 except `load_ready`=1.
- `clear` overrides everything, including mid-frame. A partially sent frame is discarded and no `sout_last` is produced for it.
- Acceptance: an edge with `load_valid` & `load_ready` loads `load_data` into the shift register and enters SHIFT.
- `load_ready` = (state==IDLE) | `sout_last`. This allows gapless back-to-back frames.
- States:
  - IDLE: `sout_valid`=0, `sout`=0. Goes to SHIFT on acceptance.
  - SHIFT: one data bit per cycle, counter 0..WIDTH-1.
    - At count WIDTH-1: go to PAR if the parity macro is defined.
    - Otherwise go to SHIFT on a new acceptance, else IDLE.
  - PAR (macro only): one parity cycle. Then SHIFT on acceptance, else IDLE.
- `sout_first`=1 only when the counter is 0 in SHIFT.
- `sout_last`=1 on the final cycle of the frame.
- `load_valid` outside `load_ready` is ignored. `load_data` is not sampled.
- Bit counter width is $clog2(WIDTH). The counter never counts past WIDTH-1 and resets to 0 on each load.

## Timing
- Latency: word accepted at edge N → first bit on `sout` during cycle N+1.
- Frame length: WIDTH cycles, or WIDTH+1 with parity.
- Back-to-back: a word accepted on the `sout_last` cycle puts its first bit in the very next cycle, so there are zero idle cycles between frames.
- All outputs are registered or decoded from registered state only. There is no combinational path from `load_valid`/`load_data` to `sout`*.
- `load_ready` depends on state only, not on `load_valid`.

## Configuration
- `SERIAL_TX_PARITY_EN` defined: an even-parity bit (XOR of all WIDTH data bits) follows the data in state PAR. `sout_last` moves to that cycle.
- Not defined: the PAR state and parity logic are absent, and `sout_last` coincides with the final data bit.

## Structure
- Package `serial_tx_pkg`:
  - state enum (IDLE, SHIFT, PAR)
  - counter-width constant/function of WIDTH
  - default WIDTH constant
- One sub-module, `serial_tx_shreg`: loadable WIDTH-bit shift register with direction per LSB_FIRST, exposing the current output bit and the XOR of the loaded word.
- The top-level holds the FSM, the counter and the handshake.

## Test plan
- WIDTH=8, LSB_FIRST=1, load 8'hA5 → `sout` = 1,0,1,0,0,1,0,1 over 8 cycles. `sout_first` on cycle 1, `sout_last` on cycle 8. With parity: a ninth bit 0 carries `sout_last`.
- LSB_FIRST=0, load 8'h81 with parity → `sout` = 1,0,0,0,0,0,0,1 then parity 0. Load 8'h01 → parity bit 1.
- Back-to-back: `load_valid` held with 8'h01 then 8'h80 → 16 (or 18) contiguous `sout_valid` cycles with `sout_first` exactly at cycles 1 and 9 (or 10).
- `load_valid`=1 with 8'hFF during SHIFT of 8'h00 (not the last cycle) → ignored; `sout` stays 0 for the whole frame.
- `clear` asserted at bit 4 of 8'hFF → the next cycle shows `sout_valid`=0, `sout`=0, `load_ready`=1. A new word 8'h0F then transmits correctly from bit 0.
- Idle hold: `load_valid`=0 for 20 cycles after reset → `sout_valid`=0, `sout`=0, `load_ready`=1 throughout.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial shift transmitter.
// Optional feature: SERIAL_TX_PARITY_EN adds an even-parity bit after the data.
package serial_tx_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    // Bit-counter width for a WIDTH-bit frame (WIDTH >= 2, so never below 1).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_shift_tx_if.sv
// Handshake (load side) and serial output bundle of the transmitter.
// master: word producer / serial consumer; slave: the transmitter itself.
interface serial_shift_tx_if import serial_tx_pkg::*; #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;

    modport master (
        output load_valid, load_data,
        input  load_ready, sout, sout_valid, sout_first, sout_last
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, sout, sout_valid, sout_first, sout_last
    );
endinterface

// File: rtl/serial_tx_shreg.sv
// Loadable WIDTH-bit shift register; shifts towards the transmit end chosen
// by LSB_FIRST and keeps the XOR of the word captured at load time.
module serial_tx_shreg import serial_tx_pkg::*; #(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout,
    output logic             parity
);
    logic [WIDTH-1:0] data_q;
    logic             parity_q;

    // Load has priority over shift so a back-to-back word replaces the old tail.
    always_ff @(posedge clk) begin
        if (clear) begin
            data_q   <= '0;
            parity_q <= 1'b0;
        end else if (load) begin
            data_q   <= din;
            parity_q <= ^din;
        end else if (shift) begin
            if (LSB_FIRST) data_q <= {1'b0, data_q[WIDTH-1:1]};
            else           data_q <= {data_q[WIDTH-2:0], 1'b0};
        end
    end

    assign dout   = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];
    assign parity = parity_q;
endmodule

// File: rtl/serial_shift_tx.sv
// Parallel-in, serial-out transmitter with valid/ready load handshake and
// first/last framing strobes. Optional macro SERIAL_TX_PARITY_EN appends an
// even-parity bit (state PAR) which then carries sout_last.
module serial_shift_tx import serial_tx_pkg::*; #(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              clear,
    serial_shift_tx_if.slave  bus
);
    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          shift_bit;
    logic          par_bit;

    serial_tx_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk    (clk),
        .clear  (clear),
        .load   (accept),
        .shift  (state_q == SHIFT),
        .din    (bus.load_data),
        .dout   (shift_bit),
        .parity (par_bit)
    );

    // State and bit-counter registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode from registered state only (no path from load_* to sout*).
    always_comb begin
        bus.sout       = 1'b0;
        bus.sout_valid = 1'b0;
        bus.sout_first = 1'b0;
        bus.sout_last  = 1'b0;
        case (state_q)
            SHIFT: begin
                bus.sout       = shift_bit;
                bus.sout_valid = 1'b1;
                bus.sout_first = (cnt_q == '0);
`ifdef SERIAL_TX_PARITY_EN
                bus.sout_last  = 1'b0;
`else
                bus.sout_last  = (cnt_q == LAST);
`endif
            end
            PAR: begin
                bus.sout       = par_bit;
                bus.sout_valid = 1'b1;
                bus.sout_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.load_ready = (state_q == IDLE) | bus.sout_last;
    assign accept         = bus.load_valid & bus.load_ready;

    // Next-state and counter; a word accepted on the last cycle restarts SHIFT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                    state_d = PAR;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PAR: begin
                state_d = accept ? SHIFT : IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule
